// File: rtl/izh_pkg.sv
// Shared types and constants for the Izhikevich spike decoder.
package izh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_REFRACT = 2'd2
    } izh_state_t;

    localparam int ISI_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int WIN_LOG2_DEF   = 10;

    // Membrane samples are v[17:10] of the 2.16 neuron state: 2 integer, 6 fraction bits.
    localparam int SAMPLE_W      = 8;
    localparam int SAMPLE_INT_W  = 2;
    localparam int SAMPLE_FRAC_W = 6;
    localparam int RATE_W        = 8;

endpackage

// File: rtl/izh_isi_fifo.sv
// Shift-register ISI buffer; entry 0 is the registered head seen by the consumer.
module izh_isi_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_n [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_s;
    logic [DEPTH-1:0] vld_n;
    logic             pop;
    logic             push_ok;
    logic             prev_vld;

    assign pop       = vld_q[0] & out_ready;
    assign full      = vld_q[DEPTH-1];
    assign out_valid = vld_q[0];
    assign out_data  = mem_q[0];
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_ok   = push & (~full | pop);

    always_comb begin
        vld_s = pop ? (vld_q >> 1) : vld_q;
        for (int i = 0; i < DEPTH - 1; i++) begin
            mem_n[i] = pop ? mem_q[i+1] : mem_q[i];
        end
        mem_n[DEPTH-1] = mem_q[DEPTH-1];
        vld_n    = vld_s;
        prev_vld = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && prev_vld && !vld_s[i]) begin
                mem_n[i] = push_data;
                vld_n[i] = 1'b1;
            end
            prev_vld = vld_s[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            mem_q <= '{default: '0};
        end else begin
            vld_q <= vld_n;
            mem_q <= mem_n;
        end
    end

endmodule

// File: rtl/izh_spike_decoder.sv
// Threshold spike detector with hysteresis, ISI capture into a small buffer,
// burst flag and windowed spike-rate count.
module izh_spike_decoder
    import izh_pkg::*;
#(
    parameter int ISI_W      = ISI_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int WIN_LOG2   = WIN_LOG2_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic signed [SAMPLE_W-1:0] v_in,
    input  logic signed [SAMPLE_W-1:0] thr,
    input  logic signed [SAMPLE_W-1:0] rearm,
    input  logic        [7:0]          burst_isi,
    output logic                       spike,
    output logic        [ISI_W-1:0]    isi_data,
    output logic                       isi_valid,
    input  logic                       isi_ready,
    output logic                       burst,
    output logic        [RATE_W-1:0]   rate,
    output logic                       overflow
);

    localparam logic [ISI_W-1:0]    ISI_MAX  = '1;
    localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

    function automatic logic [ISI_W-1:0] isi_sat_inc(input logic [ISI_W-1:0] x);
        return (x == ISI_MAX) ? x : x + 1'b1;
    endfunction

    function automatic logic [RATE_W-1:0] rate_sat_add(input logic [RATE_W-1:0] acc,
                                                       input logic inc);
        return (inc && acc != '1) ? acc + 1'b1 : acc;
    endfunction

    izh_state_t          state;
    logic [ISI_W-1:0]    isi_cnt;
    logic [ISI_W-1:0]    isi_next;
    logic [ISI_W-1:0]    burst_lim;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [RATE_W-1:0]   win_acc;
    logic [RATE_W-1:0]   win_acc_next;
    logic                fire;
    logic                fire_armed;
    logic                spike_p0;
    logic                vld_p0;
    logic [ISI_W-1:0]    isi_p0;
    logic                fifo_full;
    logic                drop;

    assign fire         = ena && (state != ST_REFRACT) && (v_in > thr);
    // Only a spike with a predecessor since reset yields a meaningful interval.
    assign fire_armed   = fire && (state == ST_ARMED);
    assign isi_next     = isi_sat_inc(isi_cnt);
    assign burst_lim    = ISI_W'(burst_isi);
    assign win_acc_next = rate_sat_add(win_acc, fire);
    assign drop         = vld_p0 && fifo_full && !(isi_valid && isi_ready);
    assign spike        = spike_p0;

    // Stage p0: detection sample registered; spike pulse and ISI push leave together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            isi_cnt  <= '0;
            win_cnt  <= '0;
            win_acc  <= '0;
            rate     <= '0;
            burst    <= 1'b0;
            overflow <= 1'b0;
            spike_p0 <= 1'b0;
            vld_p0   <= 1'b0;
        end else begin
            spike_p0 <= fire;
            vld_p0   <= fire_armed;
            if (drop) overflow <= 1'b1;
            if (ena) begin
                case (state)
                    ST_IDLE, ST_ARMED: if (v_in > thr)   state <= ST_REFRACT;
                    ST_REFRACT:        if (v_in < rearm) state <= ST_ARMED;
                    default:           state <= ST_IDLE;
                endcase
                isi_cnt <= fire ? '0 : isi_next;
                if (fire_armed)                burst <= (isi_next <= burst_lim);
                else if (isi_cnt > burst_lim)  burst <= 1'b0;
                win_cnt <= win_cnt + 1'b1;
                if (win_cnt == WIN_LAST) begin
                    rate    <= win_acc_next;
                    win_acc <= '0;
                end else begin
                    win_acc <= win_acc_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        isi_p0 <= isi_next;
    end

    izh_isi_fifo #(
        .W     (ISI_W),
        .DEPTH (FIFO_DEPTH)
    ) u_isi_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_p0),
        .push_data (isi_p0),
        .full      (fifo_full),
        .out_data  (isi_data),
        .out_valid (isi_valid),
        .out_ready (isi_ready)
    );

endmodule

// File: tb/tb_izh_spike_decoder.sv
`timescale 1ns/1ps
// Bench for izh_spike_decoder: directed table, corner sequences, random stimulus vs. model.
module tb_izh_spike_decoder;

    localparam int ISI_W    = 16;
    localparam int DEPTH    = 4;
    localparam int WIN_LOG2 = 5;
    localparam int WIN      = 1 << WIN_LOG2;
    localparam int ISI_MAX  = (1 << ISI_W) - 1;
    localparam logic signed [7:0] HI = 8'sh20;
    localparam logic signed [7:0] LO = 8'shD0;

    logic              clk = 1'b0;
    logic              rst_n, ena, isi_ready;
    logic signed [7:0] v_in, thr, rearm;
    logic [7:0]        burst_isi;
    logic              spike, isi_valid, burst, overflow;
    logic [ISI_W-1:0]  isi_data;
    logic [7:0]        rate;

    always #5 clk = ~clk;

    izh_spike_decoder #(.ISI_W(ISI_W), .FIFO_DEPTH(DEPTH), .WIN_LOG2(WIN_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .v_in(v_in), .thr(thr), .rearm(rearm),
        .burst_isi(burst_isi), .spike(spike), .isi_data(isi_data), .isi_valid(isi_valid),
        .isi_ready(isi_ready), .burst(burst), .rate(rate), .overflow(overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: sample indices since reset, spike times, a queue for the buffer.
    int unsigned m_n, m_last, m_pend_val, m_rate, m_win;
    bit          m_have_last, m_armed, m_pend, m_spike, m_burst, m_ovf, m_rst;
    int unsigned m_q[$];

    task automatic model_edge();
        int unsigned cnt, isi;
        bit det;
        m_rst = !rst_n;
        if (!rst_n) begin
            m_n = 0; m_last = 0; m_have_last = 0; m_armed = 1; m_q.delete();
            m_pend = 0; m_pend_val = 0; m_spike = 0; m_burst = 0; m_ovf = 0;
            m_rate = 0; m_win = 0;
            return;
        end
        if (m_q.size() > 0 && isi_ready) m_q.delete(0);
        if (m_pend) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_pend_val);
            else m_ovf = 1;
        end
        m_pend = 0;
        m_spike = 0;
        if (ena) begin
            cnt = m_have_last ? m_n - m_last - 1 : m_n;
            if (cnt > ISI_MAX) cnt = ISI_MAX;
            det = m_armed && (v_in > thr);
            if (det && m_have_last) begin
                isi = m_n - m_last;
                if (isi > ISI_MAX) isi = ISI_MAX;
                m_pend = 1;
                m_pend_val = isi;
                m_burst = (isi <= burst_isi);
            end else if (cnt > burst_isi) begin
                m_burst = 0;
            end
            if (det) begin
                m_have_last = 1; m_last = m_n; m_armed = 0; m_win++;
            end else if (!m_armed && v_in < rearm) begin
                m_armed = 1;
            end
            m_spike = det;
            if (m_n % WIN == WIN - 1) begin
                m_rate = (m_win > 255) ? 255 : m_win;
                m_win = 0;
            end
            m_n++;
        end
    endtask

    task automatic model_check();
        chk("m_spike", int'(spike), int'(m_spike));
        chk("m_isi_valid", int'(isi_valid), int'(m_q.size() > 0));
        if (m_q.size() > 0) chk("m_isi_data", int'(isi_data), int'(m_q[0]));
        else if (m_rst) chk("m_isi_data_rst", int'(isi_data), 0);
        chk("m_burst", int'(burst), int'(m_burst));
        chk("m_rate", int'(rate), int'(m_rate));
        chk("m_overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic samp(input logic signed [7:0] v);
        ena = 1'b1; v_in = v; step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin ena = 1'b0; step(); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b0; step(); rst_n = 1'b1;
    endtask

    task automatic train(input int cnt, input int gap);
        for (int k = 0; k < cnt; k++) begin
            samp(HI);
            if (k < cnt - 1) for (int j = 1; j < gap; j++) samp(LO);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       ena;
        logic [7:0] v;
        logic       rdy;
        logic       sp;
        logic       vl;
        int         dat;
        logic       bu;
    } vec_t;
    vec_t tbl[14];

    initial begin
        int pulses, vc, hi_pct, rdy_pct, p;

        tbl[0]  = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b1, 3, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1, 3, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 2, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 0, 1'b0};

        rst_n = 1'b0; ena = 1'b0; v_in = '0; isi_ready = 1'b0;
        thr = 8'sh10; rearm = 8'shE0; burst_isi = 8'd2;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            rst_n = tbl[i].rst_n; ena = tbl[i].ena; v_in = tbl[i].v; isi_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_spike", i), int'(spike), int'(tbl[i].sp));
            chk($sformatf("tbl%0d_valid", i), int'(isi_valid), int'(tbl[i].vl));
            chk($sformatf("tbl%0d_burst", i), int'(burst), int'(tbl[i].bu));
            if (tbl[i].vl || !tbl[i].rst_n)
                chk($sformatf("tbl%0d_data", i), int'(isi_data), tbl[i].dat);
        end
        rst_n = 1'b1;

        // First crossing after reset: spike on the cycle after sample 5, nothing buffered.
        burst_isi = 8'd0; isi_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin samp(LO); chk("r036_pre", int'(spike), 0); end
        samp(HI); chk("r036_spike", int'(spike), 1);
        samp(LO); chk("r036_pulse", int'(spike), 0);
        idle(2);  chk("r036_novalid", int'(isi_valid), 0);

        // Held above threshold must not retrigger.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin samp(HI); pulses += int'(spike); end
        samp(LO); pulses += int'(spike);
        samp(HI); pulses += int'(spike);
        samp(LO); pulses += int'(spike);
        samp(LO); pulses += int'(spike);
        chk("r038_pulses", pulses, 2);

        // Two crossings 40 samples apart with a ready consumer.
        do_reset();
        isi_ready = 1'b1;
        samp(LO);
        train(2, 40);
        idle(1);
        chk("r037_valid", int'(isi_valid), 1);
        chk("r037_data", int'(isi_data), 40);
        vc = int'(isi_valid);
        for (int i = 0; i < 4; i++) begin idle(1); vc += int'(isi_valid); end
        chk("r037_valid_cycles", vc, 1);

        // Six spikes into a stalled buffer, then drain.
        do_reset();
        isi_ready = 1'b0;
        samp(LO);
        train(6, 20);
        idle(2);
        chk("r039_overflow", int'(overflow), 1);
        chk("r039_valid", int'(isi_valid), 1);
        isi_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("r039_valid%0d", i), int'(isi_valid), 1);
            chk($sformatf("r039_data%0d", i), int'(isi_data), 20);
            idle(1);
        end
        chk("r039_empty", int'(isi_valid), 0);
        chk("r039_ovf_sticky", int'(overflow), 1);

        // Burst flag with ISIs 5,5 then a long gap; rate over a 32-sample window.
        do_reset();
        burst_isi = 8'd8; isi_ready = 1'b1;
        samp(LO);
        samp(HI); chk("r040_burst_first", int'(burst), 0);
        for (int i = 0; i < 4; i++) samp(LO);
        samp(HI); chk("r040_burst_second", int'(burst), 1);
        for (int i = 0; i < 4; i++) samp(LO);
        samp(HI); chk("r040_burst_third", int'(burst), 1);
        for (int i = 0; i < 9; i++) samp(LO);
        chk("r040_burst_at8", int'(burst), 1);
        samp(LO); chk("r040_burst_past8", int'(burst), 0);
        for (int i = 0; i < 9; i++) samp(LO);
        chk("r040_rate_before", int'(rate), 0);
        samp(LO); chk("r040_rate", int'(rate), 3);
        for (int i = 0; i < 9; i++) samp(LO);
        samp(HI); chk("r040_burst_isi30", int'(burst), 0);

        // Enable gaps do not count toward ISI; then reset mid-run.
        do_reset();
        burst_isi = 8'd8; isi_ready = 1'b0;
        samp(LO);
        samp(HI);
        for (int i = 0; i < 4; i++) samp(LO);
        idle(50);
        for (int i = 0; i < 5; i++) samp(LO);
        samp(HI);
        idle(1);
        chk("r041_valid", int'(isi_valid), 1);
        chk("r041_isi", int'(isi_data), 10);
        rst_n = 1'b0; ena = 1'b1; v_in = HI; isi_ready = 1'b1;
        step();
        rst_n = 1'b1;
        chk("r041_rst_spike", int'(spike), 0);
        chk("r041_rst_valid", int'(isi_valid), 0);
        chk("r041_rst_data", int'(isi_data), 0);
        chk("r041_rst_burst", int'(burst), 0);
        chk("r041_rst_rate", int'(rate), 0);
        chk("r041_rst_ovf", int'(overflow), 0);
        samp(LO);
        samp(HI); chk("r033_spike", int'(spike), 1);
        idle(1);  chk("r033_no_push", int'(isi_valid), 0);
        idle(1);  chk("r033_no_push2", int'(isi_valid), 0);

        // Randomized phase against the model.
        do_reset();
        for (int blk = 0; blk < 30; blk++) begin
            thr       = 8'($urandom_range(8, 64));
            rearm     = 8'(256 - $urandom_range(8, 64));
            burst_isi = 8'($urandom_range(0, 40));
            hi_pct    = $urandom_range(5, 40);
            rdy_pct   = $urandom_range(0, 100);
            for (int c = 0; c < 100; c++) begin
                ena = ($urandom_range(0, 99) < 85);
                p = $urandom_range(0, 99);
                if (p < hi_pct)      v_in = 8'($urandom_range(int'(thr) + 1, 127));
                else if (p < 90)     v_in = 8'(256 - $urandom_range(65, 128));
                else                 v_in = 8'($urandom());
                isi_ready = ($urandom_range(0, 99) < rdy_pct);
                rst_n = ($urandom_range(0, 999) != 0);
                step();
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/izh_spike_decoder.md
IZH_SPIKE_DECODER -- requirements
Module: izh_spike_decoder

Interface
REQ-001 SHALL have parameter ISI_W, default 16, width of inter-spike-interval (ISI) values.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, ISI buffer entries (power of two).
REQ-003 SHALL have parameter WIN_LOG2, default 10, rate window length of 2^WIN_LOG2 samples.
REQ-004 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ena  input  1  sample enable; v_in valid only when high.
REQ-007 SHALL have v_in  input  8  signed membrane sample from the neuron output bus (v[17:10] of 2.16, i.e. 2.6 format).
REQ-008 SHALL have thr  input  8  signed spike threshold.
REQ-009 SHALL have rearm  input  8  signed re-arm level; software keeps rearm < thr.
REQ-010 SHALL have burst_isi  input  8  unsigned burst ISI limit in samples.
REQ-011 SHALL have spike  output  1  one-cycle pulse per detected spike.
REQ-012 SHALL have isi_data  output  ISI_W  ISI at FIFO head.
REQ-013 SHALL have isi_valid  output  1  FIFO non-empty.
REQ-014 SHALL have isi_ready  input  1  consumer accepts isi_data.
REQ-015 SHALL have burst  output  1  burst-mode level flag.
REQ-016 SHALL have rate  output  8  spike count of the last completed window, saturating at 255.
REQ-017 SHALL have overflow  output  1  sticky ISI-drop flag.

Function
REQ-018 Sample: a cycle with ena=1; with ena=0 detector, ISI counter, window counter and burst SHALL hold.
REQ-019 FSM states SHALL be IDLE (armed, no prior spike), ARMED (armed, prior spike seen), REFRACT (disarmed).
REQ-020 IDLE/ARMED on sample with v_in > thr (signed) SHALL go to REFRACT and assert spike in the following cycle only.
REQ-021 REFRACT on sample with v_in < rearm (signed) SHALL go to ARMED; v_in staying above thr SHALL NOT re-trigger.
REQ-022 ISI counter SHALL clear to 0 on a spike sample, increment by 1 on each other sample, saturate at 2^ISI_W-1.
REQ-023 ISI value on a spike from ARMED SHALL be counter+1 (sample distance between spike samples), saturating; a spike from IDLE SHALL push nothing.
REQ-024 ISI value SHALL be pushed into the FIFO in the same cycle spike is asserted.
REQ-025 isi_data/isi_valid SHALL come from FIFO head registers; data stable while isi_valid=1 and isi_ready=0.
REQ-026 Pop SHALL occur when isi_valid and isi_ready are high, independent of ena.
REQ-027 Push and pop in the same cycle SHALL both occur, including when full; occupancy unchanged.
REQ-028 Push when full without pop SHALL drop the new value and set overflow until reset.
REQ-029 burst SHALL set when a pushed ISI <= burst_isi and clear when a pushed ISI > burst_isi or the ISI counter exceeds burst_isi.
REQ-030 Window counter SHALL count samples modulo 2^WIN_LOG2; on its last sample rate SHALL load the window spike count (spike on that sample included, saturated to 255) and the accumulator SHALL restart at 0.
REQ-031 Spike counting for rate SHALL use the detection sample of REQ-020.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force state IDLE, FIFO empty, all counters 0, and spike, isi_valid, isi_data, burst, rate, overflow to 0, regardless of ena or isi_ready.
REQ-033 Reset mid-operation SHALL discard buffered ISIs; the first spike after reset SHALL push nothing.

Structure
REQ-034 Shared package izh_pkg SHALL hold the FSM state type, default ISI_W/FIFO_DEPTH/WIN_LOG2 constants and the 2.6 sample format constants.
REQ-035 ISI buffer SHALL be a sub-module izh_isi_fifo (push/pop/full/empty, ready-valid output); all else in izh_spike_decoder.

Verification
REQ-036 thr=0x10, rearm=0xE0, ena=1, v_in=0xD0 then 0x20 at sample 5 -> spike high exactly at cycle 6, isi_valid stays 0.
REQ-037 Two crossings 40 samples apart, isi_ready=1 -> isi_data=40 with isi_valid high one cycle.
REQ-038 v_in held at 0x20 for 10 samples, then 0xD0, then 0x20 -> exactly two spike pulses.
REQ-039 isi_ready=0, six spikes 20 samples apart -> four entries held, overflow=1; then isi_ready=1 -> 20,20,20,20 in order, isi_valid falls.
REQ-040 burst_isi=8, ISIs 5,5,30 -> burst=1 after second spike, 0 once counter passes 8; WIN_LOG2=5 with 3 spikes in window -> rate=3.
REQ-041 ena=0 for 50 cycles between spikes 10 samples apart -> ISI=10; rst_n=0 mid-run -> all outputs 0 next cycle, FIFO empty.
